// File: rtl/alu_pkg.sv
// alu_pkg: operation and FSM state encodings shared by the iterative ALU
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLT   = 4'b0101,
    OP_SLTU  = 4'b0110,
    OP_SLL   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_SRA   = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIV   = 4'b1100,
    OP_DIVU  = 4'b1101,
    OP_REM   = 4'b1110,
    OP_REMU  = 4'b1111
  } alu_op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_e;
  function automatic logic is_iter(alu_op_e op);
    return op >= OP_MUL;
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: radix-2 shift-add multiplier / restoring divider, one step per cycle over XLEN cycles
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int CW = $clog2(XLEN);
  logic            run_q, run_d, nq_q, nq_d, nr_q, nr_d, dz_q, dz_d, sgn, mul, ld_mul;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, hi_s, lo_s;
  logic [XLEN:0]   sum, sh, diff;
  alu_op_e         op_q, op_d;
  // hi holds accumulator/partial remainder, lo holds multiplier/quotient; result comes from the step values so it is ready on the last step
  always_comb begin
    sgn    = op == OP_DIV || op == OP_REM;
    ld_mul = op == OP_MUL || op == OP_MULHU;
    mul    = op_q == OP_MUL || op_q == OP_MULHU;
    sum    = {1'b0, hi_q} + {1'b0, m_q & {XLEN{lo_q[0]}}};
    sh     = {hi_q, lo_q[XLEN-1]};
    diff   = sh - {1'b0, m_q};
    hi_s   = mul ? sum[XLEN:1] : diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
    lo_s   = mul ? {sum[0], lo_q[XLEN-1:1]} : {lo_q[XLEN-2:0], ~diff[XLEN]};
    done   = run_q && cnt_q == CW'(XLEN - 1);
    run_d  = start || (run_q && !done);
    cnt_d  = start ? '0 : run_q ? cnt_q + CW'(1) : cnt_q;
    op_d   = start ? op : op_q;
    nr_d   = start ? sgn && a[XLEN-1] : nr_q;
    nq_d   = start ? sgn && (a[XLEN-1] ^ b[XLEN-1]) : nq_q;
    dz_d   = start ? b == '0 : dz_q;
    hi_d   = start ? '0 : run_q ? hi_s : hi_q;
    lo_d   = start ? (ld_mul ? b : (sgn && a[XLEN-1]) ? -a : a) : run_q ? lo_s : lo_q;
    m_d    = start ? (ld_mul ? a : (sgn && b[XLEN-1]) ? -b : b) : m_q;
    res    = op_q == OP_MUL ? lo_s :
             op_q == OP_MULHU ? hi_s :
             (op_q == OP_DIV || op_q == OP_DIVU) ? (dz_q ? '1 : nq_q ? -lo_s : lo_s) :
             nr_q ? -hi_s : hi_s;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      op_q  <= OP_ADD;
      nr_q  <= 1'b0;
      nq_q  <= 1'b0;
      dz_q  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      m_q   <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
      nr_q  <= nr_d;
      nq_q  <= nq_d;
      dz_q  <= dz_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
    end
  end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: RV32I single-cycle ALU plus iterative mul/div behind valid/ready, registered result and zero flag
module alu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_res,
  output logic            zero
);
  localparam int SHW = $clog2(XLEN);
  alu_state_e      state_q, state_d;
  alu_op_e         op;
  logic [XLEN-1:0] res_q, res_d, fast_res, md_res;
  logic [SHW-1:0]  sh;
  logic            zero_q, zero_d, start, md_done, accept;
  assign op      = alu_op_e'(alu_ctrl);
  assign alu_res = res_q;
  assign zero    = zero_q;
  always_comb begin
    fast_res = '0;
    sh = src2[SHW-1:0];
    case (op)
      OP_ADD:  fast_res = src1 + src2;
      OP_SUB:  fast_res = src1 - src2;
      OP_AND:  fast_res = src1 & src2;
      OP_OR:   fast_res = src1 | src2;
      OP_XOR:  fast_res = src1 ^ src2;
      OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, src1 < src2};
      OP_SLL:  fast_res = src1 << sh;
      OP_SRL:  fast_res = src1 >> sh;
      OP_SRA:  fast_res = $unsigned($signed(src1) >>> sh);
      default: fast_res = '0;
    endcase
  end
  // accepting from DONE overrides the return to IDLE, giving one fast op per cycle
  always_comb begin
    in_ready  = state_q == IDLE || (state_q == DONE && out_ready);
    out_valid = state_q == DONE;
    accept    = in_valid && in_ready;
    state_d   = state_q;
    res_d     = res_q;
    start     = 1'b0;
    if (state_q == DONE && out_ready) state_d = IDLE;
    if (state_q == BUSY && md_done) begin
      state_d = DONE;
      res_d   = md_res;
    end
    if (accept) begin
      start   = is_iter(op);
      state_d = is_iter(op) ? BUSY : DONE;
      res_d   = is_iter(op) ? res_q : fast_res;
    end
    zero_d = res_d == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end
  alu_muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (src1),
    .b    (src2),
    .done (md_done),
    .res  (md_res)
  );
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed-vector bench for alu_iter with hand-computed expectations
module tb_alu_iter;
  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3, XOR_ = 4'h4, SLT = 4'h5,
                         SLTU = 4'h6, SLL = 4'h7, SRL = 4'h8, SRA = 4'h9, MUL = 4'hA, MULHU = 4'hB,
                         DIV = 4'hC, DIVU = 4'hD, REM = 4'hE, REMU = 4'hF;
  localparam logic [3:0]  BB_OP [10] = '{SUB, SRA, AND_, OR_, XOR_, SLT, SLTU, SLL, SRL, ADD};
  localparam logic [31:0] BB_A  [10] = '{32'd5, 32'h8000_0000, 32'hF0F0_1234, 32'hF000_0000, 32'hAAAA_AAAA,
                                         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF};
  localparam logic [31:0] BB_B  [10] = '{32'd5, 32'h21, 32'h0FF0_FF00, 32'h0000_000F, 32'hFFFF_FFFF,
                                         32'h1, 32'h1, 32'h3F, 32'h24, 32'h1};
  localparam logic [31:0] BB_E  [10] = '{32'h0, 32'hC000_0000, 32'h00F0_1200, 32'hF000_000F, 32'h5555_5555,
                                         32'h1, 32'h0, 32'h8000_0000, 32'h0800_0000, 32'h0};
  localparam logic [3:0]  IT_OP [12] = '{MUL, MULHU, DIV, REM, DIVU, REMU, DIV, REM, DIV, REM, DIVU, REMU};
  localparam logic [31:0] IT_A  [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7,
                                         32'h8000_0000, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'd100, 32'd100};
  localparam logic [31:0] IT_B  [12] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0,
                                         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd7, 32'd7};
  localparam logic [31:0] IT_E  [12] = '{32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7,
                                         32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd14, 32'd2};
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, zero;
  logic [3:0]  alu_ctrl = 4'h0;
  logic [31:0] src1 = '0, src2 = '0, alu_res;
  int vecs = 0, errs = 0;
  alu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl),
    .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready), .alu_res(alu_res), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_ctrl = op; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678;
  endtask
  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; alu_ctrl = ADD; src1 = 32'h1; src2 = 32'h1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    vecs++;
    if (alu_res !== 32'h0 || zero !== 1'b1) begin
      errs++; $display("FAIL reset_res: alu_res=%h zero=%b, want 00000000 1", alu_res, zero);
    end
  endtask
  task automatic test_add;
    out_ready = 1'b1;
    issue(ADD, 32'h7FFF_FFFF, 32'h1);
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b1 || alu_res !== 32'h8000_0000 || zero !== 1'b0) begin
      errs++; $display("FAIL add: out_valid=%b alu_res=%h zero=%b, want 1 80000000 0", out_valid, alu_res, zero);
    end
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL add_consumed: out_valid=%b, want 0", out_valid);
    end
  endtask
  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      alu_ctrl = BB_OP[i]; src1 = BB_A[i]; src2 = BB_B[i]; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vecs++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || alu_res !== BB_E[i] || zero !== (BB_E[i] == 32'h0)) begin
        errs++;
        $display("FAIL b2b[%0d]: out_valid=%b in_ready=%b alu_res=%h zero=%b, want 1 1 %h %b",
                 i, out_valid, in_ready, alu_res, zero, BB_E[i], BB_E[i] == 32'h0);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL b2b_drain: out_valid=%b, want 0", out_valid);
    end
  endtask
  task automatic run_iter(input int idx);
    int k;
    for (k = 0; k < 50 && in_ready !== 1'b1; k++) @(negedge clk);
    issue(IT_OP[idx], IT_A[idx], IT_B[idx]);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        vecs++;
        if (in_ready !== 1'b0) begin
          errs++; $display("FAIL iter_busy[%0d]: in_ready=%b, want 0", idx, in_ready);
        end
      end
      if (out_valid === 1'b1) break;
    end
    vecs++;
    if (k != 33) begin
      errs++; $display("FAIL iter_latency[%0d]: cycles=%0d, want 33", idx, k);
    end
    vecs++;
    if (alu_res !== IT_E[idx] || zero !== (IT_E[idx] == 32'h0)) begin
      errs++;
      $display("FAIL iter_res[%0d]: alu_res=%h zero=%b, want %h %b", idx, alu_res, zero, IT_E[idx], IT_E[idx] == 32'h0);
    end
  endtask
  task automatic test_iter;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) run_iter(i);
  endtask
  task automatic test_backpressure;
    @(negedge clk);
    out_ready = 1'b0;
    issue(ADD, 32'd3, 32'd4);
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b1 || alu_res !== 32'd7) begin
      errs++; $display("FAIL bp_first: out_valid=%b alu_res=%h, want 1 00000007", out_valid, alu_res);
    end
    alu_ctrl = ADD; src1 = 32'd1; src2 = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_res !== 32'd7 || zero !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b alu_res=%h zero=%b, want 1 0 00000007 0",
                 i, out_valid, in_ready, alu_res, zero);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b1 || alu_res !== 32'd2) begin
      errs++; $display("FAIL bp_next: out_valid=%b alu_res=%h, want 1 00000002", out_valid, alu_res);
    end
  endtask
  task automatic test_reset_abort;
    logic seen;
    out_ready = 1'b1;
    issue(DIVU, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b0 || alu_res !== 32'h0 || zero !== 1'b1 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL abort: out_valid=%b alu_res=%h zero=%b in_ready=%b, want 0 00000000 1 1", out_valid, alu_res, zero, in_ready);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0) begin
      errs++; $display("FAIL abort_stale: out_valid seen=%b, want 0", seen);
    end
    issue(ADD, 32'd2, 32'd3);
    @(negedge clk);
    vecs++;
    if (out_valid !== 1'b1 || alu_res !== 32'd5) begin
      errs++; $display("FAIL abort_recover: out_valid=%b alu_res=%h, want 1 00000005", out_valid, alu_res);
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_iter();
    test_backpressure();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
